// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: address/RW selects, FSM states.
// Also carries the wait-state limit used to clamp the counter load.
package mem_responder_pkg;

  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    PC_ADDR = 2'd0,
    A_ADDR  = 2'd1
  } mm_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mw_t;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } mresp_state_t;

  function automatic logic [CNT_W-1:0] ws_load(input int ws);
    int c;
    c = (ws > MAX_WAIT_STATES) ? MAX_WAIT_STATES : ws;
    c = (c < 0) ? 0 : c;
    return CNT_W'(c);
  endfunction

endpackage

// File: rtl/mem_responder_wait.sv
// Loadable 4-bit down-counter; saturates at zero and flags it.
// Load has priority over decrement.
module wait_counter
  import mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign count = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, drives memory for
// 1+WAIT_STATES cycles, then pulses ready with the captured read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  mm_t               mm,
  input  mw_t               mw,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] areg,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WS_LD = ws_load(WAIT_STATES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  mresp_state_t      state;
  mresp_state_t      state_nx;
  logic [ADDR_W-1:0] addr_mux;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  mw_t               mw_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              take;
  logic              dec;
  logic              last;

  always_comb begin
    addr_mux = pc;
    unique case (1'b1)
      (mm == A_ADDR): addr_mux = areg;
      default:        addr_mux = pc;
    endcase
  end

  wait_counter u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take),
    .dec      (dec),
    .load_val (WS_LD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    dec      = 1'b0;
    last     = 1'b0;
    busy     = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        take     = req;
        state_nx = req ? ACCESS : IDLE;
      end
      ACCESS: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = (mw_q == WRITE);
        last     = cnt_zero;
        state_nx = cnt_zero ? DONE : WAIT;
      end
      WAIT: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = (mw_q == WRITE);
        dec      = 1'b1;
        // <=1 rather than ==1 so a stray zero can never hang here
        last     = (cnt <= ONE);
        state_nx = last ? DONE : WAIT;
      end
      DONE: begin
        ready    = 1'b1;
        take     = req;
        state_nx = req ? ACCESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mw_q    <= READ;
    end else begin
      if (take) begin
        addr_q  <= addr_mux;
        wdata_q <= wdata;
        mw_q    <= mw;
      end
      if (last && (mw_q == READ)) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the mos6502 core's control unit. It accepts an access request qualified by the `mm_t` address-source select and the `mw_t` read/write select, and drives a single-port external memory with a configurable number of wait states. It returns latched read data with a one-cycle `ready` pulse. It sits between `control` plus the PC/address registers and the memory array.

## Interface
- `WAIT_STATES`, 1: extra enabled cycles per access after the first. Legal range 0..15.
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, sampled in IDLE and DONE.
- `mm`  in  `mm_t`  address source. `PC_ADDR` selects `pc`, `A_ADDR` selects `areg`, any other value selects `pc`.
- `mw`  in  `mw_t`  `READ` or `WRITE`.
- `pc`  in  ADDR_W  program counter address.
- `areg`  in  ADDR_W  address register.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  last completed read data.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in ACCESS and WAIT.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- **States:** IDLE, ACCESS, WAIT, DONE.
- **Request capture (IDLE or DONE, `req`=1):**
  - Latch the muxed address, `mw` and `wdata` into internal registers.
  - Load the wait counter with WAIT_STATES.
  - Go to ACCESS.
- **IDLE or DONE, `req`=0:** go to IDLE.
- **ACCESS:**
  - `mem_en`=1.
  - `mem_we`=1 if the latched `mw` is `WRITE`.
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - Next state is WAIT if the counter is nonzero, else DONE.
- **WAIT:**
  - Same memory drive as ACCESS, held stable.
  - Counter decrements each cycle; leave for DONE on the cycle the counter is 1.
- **Read data capture:** `mem_rdata` is sampled into `rdata` at the edge that ends the last enabled cycle, for reads only. Writes leave `rdata` unchanged.
- **Memory contract:** memory presents valid read data within 1+WAIT_STATES enabled cycles. Synchronous block RAM requires WAIT_STATES≥1.
- **DONE:** `ready`=1, `mem_en`=0, `mem_we`=0.
- **`req` while busy:** ignored. Inputs `pc`, `areg`, `mm`, `mw` and `wdata` may change freely after capture.
- **Counter width:** 4 bits, no wrap. The counter never decrements below 0.
- **Reset (any state, including mid-access):**
  - State goes to IDLE.
  - `mem_en`, `mem_we`, `ready` and `busy` go to 0 immediately, without waiting for a clock edge.
  - `rdata`, `mem_addr` and `mem_wdata` go to 0.
  - The interrupted access is abandoned with no `ready` pulse.

## Timing
- Request sampled at edge N. ACCESS runs in cycle N+1, WAIT in N+2..N+1+WAIT_STATES, DONE in N+2+WAIT_STATES.
- `ready` latency from request edge is WAIT_STATES+2 cycles.
- `rdata` is valid from the DONE cycle until the next read's DONE.
- Back-to-back: `req`=1 during DONE starts the next ACCESS in the following cycle. Peak throughput is one access per WAIT_STATES+2 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `req` to `mem_*`.

## Structure
- In `common_types`:
  - add `mresp_state_t` enum {IDLE, ACCESS, WAIT, DONE};
  - reuse the existing `mm_t`, `mw_t` and `data_t`;
  - add localparam `MAX_WAIT_STATES` = 15.
- The address mux is a plain combinational case inside the block.
- One natural sub-module: `wait_counter`, a loadable 4-bit down-counter with a `zero` flag.
- Bench memory model: behavioural array with programmable latency, written in the testbench.

## Test plan
- **Read, no wait:** WAIT_STATES=0, `mm`=`PC_ADDR`, `pc`=0x1234, memory[0x1234]=0xA9, `req` pulse at edge 0 → `mem_en`=1 in cycle 1 with `mem_addr`=0x1234; `ready`=1 in cycle 2; `rdata`=0xA9.
- **Write with wait states:** WAIT_STATES=2, `mm`=`A_ADDR`, `areg`=0x00FF, `mw`=`WRITE`, `wdata`=0x5C → `mem_en`=`mem_we`=1 for exactly 3 cycles; `ready` at latency 4; memory[0x00FF]=0x5C; `rdata` unchanged.
- **Back-to-back reads:** WAIT_STATES=1, `req` held high, addresses 0x0010 then 0x0011 → two `ready` pulses 3 cycles apart; `rdata` updates to each location's value in turn.
- **Input change while busy:** change `pc`/`areg`/`mm` and pulse `req` during WAIT → `mem_addr` stays at the latched value; no extra access; exactly one `ready`.
- **Reset mid-access:** assert `rst_n`=0 during WAIT of a write → `mem_en`/`mem_we` drop immediately; no `ready`; after release the block is in IDLE and `rdata`=0.
- **Illegal `mm` encoding:** `mm` set to an unused value → `mem_addr` equals `pc`.
